// File: rtl/regfile_sb.sv
// Register file x0..x31 with same-cycle writeback bypass and per-register
// saturating pending-write counters that drive the decode stall.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            WriteEnable,
  input  logic [4:0]      WriteReg,
  input  logic [XLEN-1:0] WriteData,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            issue_valid,
  input  logic            issue_uses_rs1,
  input  logic            issue_uses_rs2,
  input  logic            issue_we,
  input  logic [4:0]      issue_rd,
  input  logic            flush,
  output logic            stall,
  output logic [31:0]     busy
);

  logic [XLEN-1:0] r_regs [1:31];
  logic [CW-1:0]   r_cnt  [1:31];

  logic [31:0] w_ready;
  logic [31:0] w_full;
  logic [31:0] w_inc;
  logic [31:0] w_dec;
  logic        w_accept;

  always_comb begin
    rd1 = '0;
    if (rs1 != 5'd0)
      rd1 = (WriteEnable && WriteReg == rs1) ? WriteData : r_regs[rs1];
  end

  always_comb begin
    rd2 = '0;
    if (rs2 != 5'd0)
      rd2 = (WriteEnable && WriteReg == rs2) ? WriteData : r_regs[rs2];
  end

  // A source whose only remaining producer writes back this cycle is ready
  // because its value reaches decode through the bypass.
  always_comb begin
    w_ready = '1;
    w_full  = '0;
    busy    = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      busy[i]    = (r_cnt[i] != '0);
      w_full[i]  = (r_cnt[i] == '1);
      w_ready[i] = (r_cnt[i] == '0) ||
                   ((r_cnt[i] == CW'(1)) && WriteEnable && (WriteReg == 5'(i)));
    end
  end

  assign stall = issue_valid &
                 ((issue_uses_rs1 & ~w_ready[rs1]) |
                  (issue_uses_rs2 & ~w_ready[rs2]) |
                  (issue_we & (issue_rd != 5'd0) & w_full[issue_rd]));

  assign w_accept = issue_valid & ~stall & ~flush & issue_we & (issue_rd != 5'd0);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      w_inc[i] = w_accept && (issue_rd == 5'(i));
      w_dec[i] = WriteEnable && (WriteReg == 5'(i)) && (r_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      if (WriteEnable && WriteReg != 5'd0)
        r_regs[WriteReg] <= WriteData;
      for (int unsigned i = 1; i < 32; i++) begin
        if (flush)
          r_cnt[i] <= '0;
        else if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + CW'(1);
        else if (w_dec[i] && !w_inc[i])
          r_cnt[i] <= r_cnt[i] - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            WriteEnable;
  logic [4:0]      WriteReg;
  logic [XLEN-1:0] WriteData;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rd1, rd2;
  logic            issue_valid, issue_uses_rs1, issue_uses_rs2, issue_we;
  logic [4:0]      issue_rd;
  logic            flush;
  logic            stall;
  logic [31:0]     busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] m_regs [32];
  int              m_cnt  [32];
  logic            e_stall;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .WriteEnable(WriteEnable), .WriteReg(WriteReg), .WriteData(WriteData),
    .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
    .issue_valid(issue_valid), .issue_uses_rs1(issue_uses_rs1),
    .issue_uses_rs2(issue_uses_rs2), .issue_we(issue_we), .issue_rd(issue_rd),
    .flush(flush), .stall(stall), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_ready(input int r);
    return (r == 0) || (m_cnt[r] == 0) ||
           (m_cnt[r] == 1 && WriteEnable && int'(WriteReg) == r);
  endfunction

  function automatic logic [XLEN-1:0] m_read(input int r);
    if (r == 0) return '0;
    if (WriteEnable && int'(WriteReg) == r) return WriteData;
    return m_regs[r];
  endfunction

  // Compare all combinational outputs against the model for the current inputs.
  task automatic eval(input string tag);
    logic [31:0] e_busy;
    #1;
    e_stall = issue_valid &&
              ((issue_uses_rs1 && !m_ready(int'(rs1))) ||
               (issue_uses_rs2 && !m_ready(int'(rs2))) ||
               (issue_we && issue_rd != 0 && m_cnt[issue_rd] == MAXC));
    e_busy = '0;
    for (int r = 1; r < 32; r++) e_busy[r] = (m_cnt[r] != 0);
    check({tag, ".rd1"},   64'(rd1),   64'(m_read(int'(rs1))));
    check({tag, ".rd2"},   64'(rd2),   64'(m_read(int'(rs2))));
    check({tag, ".stall"}, 64'(stall), 64'(e_stall));
    check({tag, ".busy"},  64'(busy),  64'(e_busy));
  endtask

  // Advance one clock and apply the architectural update rules to the model.
  task automatic tick();
    bit dec_ok;
    @(posedge clk);
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
    end else begin
      dec_ok = WriteEnable && WriteReg != 0 && m_cnt[WriteReg] > 0;
      if (WriteEnable && WriteReg != 0) m_regs[WriteReg] = WriteData;
      if (flush) begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else begin
        if (issue_valid && !e_stall && issue_we && issue_rd != 0) m_cnt[issue_rd]++;
        if (dec_ok) m_cnt[WriteReg]--;
      end
    end
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; WriteEnable = 1'b0; WriteReg = '0; WriteData = '0;
    rs1 = '0; rs2 = '0; issue_valid = 1'b0; issue_uses_rs1 = 1'b0;
    issue_uses_rs2 = 1'b0; issue_we = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic issue_to(input logic [4:0] rd);
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    WriteEnable = 1'b1; WriteReg = r; WriteData = d;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin m_regs[r] = 'x; m_cnt[r] = 0; end
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    tick();

    // Reset state with a full issue request pending
    idle(); issue_valid = 1'b1; issue_uses_rs1 = 1'b1; issue_uses_rs2 = 1'b1;
    rs1 = 5'd5; rs2 = 5'd9;
    eval("rst");
    check("rst.stall0", 64'(stall), 64'd0);
    check("rst.busy0",  64'(busy),  64'd0);
    check("rst.rd1z",   64'(rd1),   64'd0);
    tick();

    // Write then read back; x0 discards writes
    idle(); wb(5'd5, 32'hDEADBEEF); eval("w5"); tick();
    idle(); rs1 = 5'd5; eval("r5");
    check("r5.val", 64'(rd1), 64'hDEADBEEF); tick();
    idle(); wb(5'd0, 32'h1234); rs2 = 5'd0; eval("w0");
    check("w0.byp", 64'(rd2), 64'd0); tick();
    idle(); rs2 = 5'd0; eval("r0");
    check("r0.val", 64'(rd2), 64'd0); tick();

    // Same-cycle bypass
    idle(); wb(5'd7, 32'h11); eval("w7a"); tick();
    idle(); wb(5'd7, 32'h22); rs1 = 5'd7; eval("byp7");
    check("byp7.val", 64'(rd1), 64'h22); tick();
    idle(); rs1 = 5'd7; eval("r7");
    check("r7.val", 64'(rd1), 64'h22); tick();

    // RAW stall released by the producer's writeback
    idle(); issue_to(5'd3); eval("raw.iss"); tick();
    idle(); eval("raw.busy");
    check("raw.busy3", 64'(busy[3]), 64'd1);
    issue_valid = 1'b1; issue_uses_rs1 = 1'b1; rs1 = 5'd3; eval("raw.dep");
    check("raw.stall", 64'(stall), 64'd1); tick();
    wb(5'd3, 32'hABCD); eval("raw.wb");
    check("raw.go",  64'(stall), 64'd0);
    check("raw.fwd", 64'(rd1),   64'hABCD); tick();

    // WAW counting up to saturation
    idle();
    for (int k = 0; k < 3; k++) begin issue_to(5'd9); eval("waw.iss"); tick(); end
    issue_to(5'd9); eval("waw.sat");
    check("waw.stall", 64'(stall), 64'd1); tick();
    idle(); wb(5'd9, 32'h9); eval("waw.wb1"); tick();
    idle(); eval("waw.b1");
    check("waw.busy9a", 64'(busy[9]), 64'd1);
    for (int k = 0; k < 2; k++) begin idle(); wb(5'd9, 32'h90 + k); eval("waw.wbn"); tick(); end
    idle(); eval("waw.b0");
    check("waw.busy9b", 64'(busy[9]), 64'd0);

    // Simultaneous issue and writeback, then writeback with no pending producer
    idle(); issue_to(5'd4); eval("sim.iss"); tick();
    issue_to(5'd4); wb(5'd4, 32'h44); eval("sim.both"); tick();
    idle(); eval("sim.chk");
    check("sim.busy4", 64'(busy[4]), 64'd1);
    wb(5'd4, 32'h45); eval("sim.wb"); tick();
    idle(); wb(5'd4, 32'h46); eval("sim.wb0"); tick();
    idle(); rs1 = 5'd4; eval("sim.rd");
    check("sim.rd4",   64'(rd1),     64'h46);
    check("sim.idle4", 64'(busy[4]), 64'd0); tick();

    // Flush with a same-cycle issue
    idle(); issue_to(5'd3); eval("fl.a"); tick();
    issue_to(5'd9); eval("fl.b"); tick();
    idle(); eval("fl.pre");
    check("fl.busy208", 64'(busy), 64'h208);
    issue_to(5'd6); flush = 1'b1; eval("fl.go"); tick();
    idle(); eval("fl.post");
    check("fl.busy0", 64'(busy), 64'd0);

    // Reset mid-stream
    idle(); issue_to(5'd12); wb(5'd5, 32'h5555); eval("mr.a"); tick();
    idle(); rst_n = 1'b0; issue_to(5'd13); wb(5'd6, 32'h66); tick();
    idle(); rs1 = 5'd5; rs2 = 5'd6; eval("mr.post");
    check("mr.rd1",  64'(rd1),  64'd0);
    check("mr.busy", 64'(busy), 64'd0);
    wb(5'd12, 32'h1212); eval("mr.late"); tick();
    idle(); rs1 = 5'd12; eval("mr.late2");
    check("mr.late", 64'(rd1), 64'h1212); tick();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      rst_n          = ($urandom_range(0, 299) != 0);
      flush          = ($urandom_range(0, 59) == 0);
      issue_valid    = $urandom_range(0, 1);
      issue_we       = ($urandom_range(0, 3) != 0);
      issue_uses_rs1 = $urandom_range(0, 1);
      issue_uses_rs2 = $urandom_range(0, 1);
      issue_rd       = 5'($urandom_range(0, 7));
      rs1            = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rs2            = 5'($urandom_range(0, 7));
      WriteEnable    = $urandom_range(0, 1);
      WriteReg       = 5'($urandom_range(0, 7));
      WriteData      = $urandom;
      if (rst_n) eval("rnd");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
